display_scanner: RTL and testbench
==================================

Name: display_scanner

Overview:
- Time-multiplexed driver for an 8-digit seven-segment display showing a 32-bit word as 8 hex digits.
- A free-running prescaler counter advances a 3-bit digit-select index.
- The selected nibble is decoded to a segment pattern.
- Sits between any 32-bit value source (register file, debug bus) and the board's digit-select/segment pins.

Parameters:
- CNT_WIDTH, 15, width of the prescaler counter; the digit index advances once per 2^CNT_WIDTH clocks.

Ports:
- clk    input   1          system clock, all state on rising edge
- rst    input   1          synchronous reset, active-high
- data   input   32         value to display; digit k shows data[4k+3:4k]
- which  output  3          currently selected digit index (0 = least significant nibble)
- seg    output  8          segment pattern for selected digit; bit0=a … bit6=g, bit7=dp
- count  output  CNT_WIDTH  current prescaler value (exposed for debug/test)
- digit  output  4          raw nibble currently selected

Behaviour:
- Registers: count (CNT_WIDTH bits), which (3 bits). Nothing else is stored.
- Reset: on a rising clk with rst=1, count<=0 and which<=0. rst has priority over counting.
  - After reset: digit=data[3:0] and seg=decode(data[3:0]).
- Counting, each rising clk with rst=0:
  - count <= count+1, modulo 2^CNT_WIDTH.
  - When count == all-ones (2^CNT_WIDTH−1), on that same edge count wraps to 0 and which <= which+1.
  - which wraps 7→0.
  - which therefore changes exactly once per 2^CNT_WIDTH cycles and never without a count wrap.
- Digit select is combinational, zero latency from which and data:
  - digit = data[4*which+3 : 4*which].
  - which=0 → data[3:0]; which=7 → data[31:28].
- data may change at any time. digit/seg follow it combinationally within the same cycle; data is not latched.
- Segment decode is combinational from digit. Segments are active-high (1 = lit); dp (bit7) is always 0.
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- Outputs which and count are the register values directly (no extra pipeline).
- No handshake; the block free-runs continuously.
- Reset asserted mid-scan restarts at digit 0 with count 0 on the next edge.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined:
  - seg is the bitwise inverse of the active-high pattern, including dp, so blank dp = 1. For common-anode boards.
  - Example: digit 0 → seg=C0.
- Undefined: active-high table above, dp=0.
- which, digit, count are unaffected either way.

Test Plan:
- Reset: rst=1 for 2 clocks, data=FEDCBA98 → count=0, which=0, digit=8, seg=7F.
- Prescaler, CNT_WIDTH=3: release rst → which steps 0→1 on the 8th clock edge after reset, with count 7→0 on that edge; which=1 gives digit=9, seg=6F.
- Full scan, data=FEDCBA98, CNT_WIDTH=3, sampled per digit:
  - digit sequence 8,9,A,B,C,D,E,F; seg sequence 7F,6F,77,7C,39,5E,79,71.
  - which wraps 7→0 after 64 clocks.
- Data change, data=76543210 mid-scan:
  - which=2 → digit=2, seg=5B immediately, same cycle.
  - Full scan gives seg 3F,06,5B,4F,66,6D,7D,07.
- Reset mid-scan: assert rst at which=5, count=3 → next edge which=0, count=0; digit=data[3:0].
- SEG_ACTIVE_LOW_EN defined, data=00000000 → seg=C0; data nibble 8 → seg=80.

Source files
------------

// File: rtl/display_scanner.sv
// Eight-digit hex seven-segment scanner: prescaled digit rotation plus nibble decode.
// Define SEG_ACTIVE_LOW_EN to invert all segment outputs for common-anode boards.
module display_scanner #(
  parameter int CNT_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          data,
  output logic [2:0]           which,
  output logic [7:0]           seg,
  output logic [CNT_WIDTH-1:0] count,
  output logic [3:0]           digit
);

  logic [7:0] seg_hi;
  logic       wrap;

  assign wrap = &count;

  // which only moves on the prescaler wrap edge
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      which <= '0;
    end else begin
      count <= count + CNT_WIDTH'(1);
      if (wrap) begin
        which <= which + 3'd1;
      end
    end
  end

  assign digit = data[{which, 2'b00} +: 4];

  always_comb begin
    seg_hi = 8'h00;
    unique case (digit)
      4'h0: seg_hi = 8'h3F;
      4'h1: seg_hi = 8'h06;
      4'h2: seg_hi = 8'h5B;
      4'h3: seg_hi = 8'h4F;
      4'h4: seg_hi = 8'h66;
      4'h5: seg_hi = 8'h6D;
      4'h6: seg_hi = 8'h7D;
      4'h7: seg_hi = 8'h07;
      4'h8: seg_hi = 8'h7F;
      4'h9: seg_hi = 8'h6F;
      4'hA: seg_hi = 8'h77;
      4'hB: seg_hi = 8'h7C;
      4'hC: seg_hi = 8'h39;
      4'hD: seg_hi = 8'h5E;
      4'hE: seg_hi = 8'h79;
      4'hF: seg_hi = 8'h71;
    endcase
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign seg = ~seg_hi;
`else
  assign seg = seg_hi;
`endif

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with a 3-bit prescaler.
// Expected segment patterns come from a hand-written table.
module tb_display_scanner;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   data;
  logic [2:0]    which;
  logic [7:0]    seg;
  logic [CW-1:0] count;
  logic [3:0]    digit;

  int errors = 0;
  int checks = 0;

  logic [7:0] segtab [16];

  display_scanner #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .which (which),
    .seg   (seg),
    .count (count),
    .digit (digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [3:0] n);
    logic [7:0] t;
    t = segtab[n];
`ifdef SEG_ACTIVE_LOW_EN
    t = ~t;
`endif
    return t;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    segtab = '{8'h3F, 8'h06, 8'h5B, 8'h4F,
               8'h66, 8'h6D, 8'h7D, 8'h07,
               8'h7F, 8'h6F, 8'h77, 8'h7C,
               8'h39, 8'h5E, 8'h79, 8'h71};
    rst  = 1'b1;
    data = 32'hFEDCBA98;
    tick(2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_which", 32'(which), 32'd0);
    chk("rst_digit", 32'(digit), 32'h8);
    chk("rst_seg", 32'(seg), 32'(exp_seg(4'h8)));

    rst = 1'b0;
    tick(7);
    chk("pre_count7", 32'(count), 32'd7);
    chk("pre_which0", 32'(which), 32'd0);
    tick(1);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_which", 32'(which), 32'd1);
    chk("wrap_digit", 32'(digit), 32'h9);
    chk("wrap_seg", 32'(seg), 32'(exp_seg(4'h9)));

    for (int k = 2; k < 8; k++) begin
      tick(8);
      chk("scan_which", 32'(which), 32'(k));
      chk("scan_digit", 32'(digit), 32'(k + 8));
      chk("scan_seg", 32'(seg), 32'(exp_seg(4'(k + 8))));
    end
    tick(8);
    chk("scan_wrap_which", 32'(which), 32'd0);
    chk("scan_wrap_digit", 32'(digit), 32'h8);

    tick(16);
    chk("mid_which", 32'(which), 32'd2);
    data = 32'h76543210;
    #1;
    chk("chg_digit", 32'(digit), 32'h2);
    chk("chg_seg", 32'(seg), 32'(exp_seg(4'h2)));

    for (int i = 0; i < 8; i++) begin
      chk("scan2_which", 32'(which), 32'((2 + i) % 8));
      chk("scan2_seg", 32'(seg), 32'(exp_seg(4'((2 + i) % 8))));
      tick(8);
    end

    tick(27);
    chk("pre_rst_which", 32'(which), 32'd5);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("mrst_which", 32'(which), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_digit", 32'(digit), 32'h0);

    data = 32'h00000000;
    #1;
    chk("zero_seg", 32'(seg), 32'(exp_seg(4'h0)));
    data = 32'h00000008;
    #1;
    chk("eight_seg", 32'(seg), 32'(exp_seg(4'h8)));
    chk("seg_dp", 32'(seg[7]), 32'(exp_seg(4'h8) >> 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
